line_mem_responder: RTL and testbench
=====================================

Name: line_mem_responder

Overview:
- Memory-side responder for the 128-bit line interface driven by the read-only instruction cache and the data cache.
- Accepts one line read or line write at a time, waits a programmable latency, then completes it with a single-cycle mem_ready pulse.
- Serves as the synthesizable slow-memory model behind the caches in system simulation and FPGA builds.
- Stores lines verbatim; performs no byte or halfword reordering.

Parameters:
- LATENCY, 8, cycles from request acceptance to the mem_ready pulse; legal range 1..255.
- DEPTH_LOG2, 10, log2 of the number of 128-bit lines stored.
- ADDR_W, 28, line address width.
- DATA_W, 128, line width.

Ports:
- clk  input  1  clock, all logic on rising edge
- proc_reset  input  1  synchronous active-high reset
- mem_read  input  1  line read request, held by the requester until mem_ready
- mem_write  input  1  line write request, held by the requester until mem_ready
- mem_addr  input  ADDR_W  line address
- mem_wdata  input  DATA_W  write line data
- mem_rdata  output  DATA_W  read line data, registered
- mem_ready  output  1  one-cycle completion pulse, registered

Behaviour:
- Reset and interface:
  - One clock, clk. Reset proc_reset is synchronous and active-high.
  - Reset values: mem_ready=0, mem_rdata=0, state=IDLE, latency counter=0, latched op, address and data=0.
  - The storage array is not cleared. Lines never written read as X in simulation.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If mem_read|mem_write is high at a rising edge, latch op, mem_addr and mem_wdata.
  - Load the counter with LATENCY-1 and go to BUSY. If LATENCY=1, go directly to RESP.
  - mem_write has priority when both requests are high; the op is treated as a write.
- BUSY:
  - Decrement the counter each cycle. Move to RESP when the counter reaches 1.
  - Request and address inputs are ignored; the latched copies are used.
- RESP:
  - This is the only cycle with mem_ready=1. It occurs exactly LATENCY cycles after the accepting edge.
  - Read: mem_rdata becomes array[latched_addr[DEPTH_LOG2-1:0]] in the same cycle mem_ready is high. The cache captures data in that cycle.
  - Write: the array entry is updated at the edge that ends RESP. mem_rdata is unchanged.
  - The next state is always IDLE.
- mem_rdata holds its last read value until the next read completes.
- Back-to-back requests:
  - The requester drops its request in the cycle after mem_ready.
  - A request still high in IDLE is accepted as a new transaction. Minimum spacing is LATENCY+1 cycles between mem_ready pulses.
- Address wrap: only the low DEPTH_LOG2 bits index the array. Upper bits are ignored, so addresses alias modulo 2^DEPTH_LOG2.
- Read-after-write to the same line: a read accepted after the write's RESP returns the new data.
- Reset mid-operation:
  - Return to IDLE and clear mem_ready and mem_rdata.
  - A pending write is dropped and the array is not modified.
- Requests that drop before mem_ready (protocol violation): the transaction still completes and mem_ready still pulses.
- mem_ready is never high for two consecutive cycles.

Test Plan:
- Reset then write: LATENCY=8, mem_write=1, mem_addr=28'h0000010, mem_wdata=128'h00112233_44556677_8899AABB_CCDDEEFF held until ready -> mem_ready pulses once, exactly 8 cycles after the accepting edge.
- Read back: read mem_addr=28'h0000010 -> mem_ready pulses after 8 cycles with mem_rdata=128'h00112233_44556677_8899AABB_CCDDEEFF in the same cycle; mem_rdata holds afterwards.
- Alias and priority:
  - With DEPTH_LOG2=10, write line 28'h0000405 with 128'h1, then read 28'h0000005 -> returns 128'h1.
  - Assert both read and write -> treated as a write; mem_rdata is unchanged.
- Input change during BUSY: accept a read at 28'h10, change mem_addr to 28'h20 during BUSY -> data of line 28'h10 is returned.
- Reset mid-write: accept a write of 128'hDEAD at 28'h30, assert proc_reset 3 cycles later -> mem_ready stays 0; a subsequent read of 28'h30 returns the prior contents.
- Held request and LATENCY=1:
  - Keep mem_read high continuously -> ready pulses every LATENCY+1 cycles, never two adjacent cycles.
  - With LATENCY=1 -> mem_ready is high in the cycle after acceptance.

Source files
------------

// File: rtl/line_mem_responder.sv
// Slow-memory responder for the 128-bit cache line interface.
// It accepts one line read or write, waits LATENCY cycles, then pulses mem_ready for one cycle.
module line_mem_responder #(
  parameter int LATENCY    = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t                  r_state;
  logic [7:0]              r_cnt;
  logic                    r_op_wr;
  logic [DEPTH_LOG2-1:0]   r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_ready;
  logic [DATA_W-1:0]       r_mem [2**DEPTH_LOG2];

  logic                    w_req;
  logic [DEPTH_LOG2-1:0]   w_rd_idx;
  logic                    w_unused_addr_hi;

  // Upper address bits alias onto the same lines.
  assign w_unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

  always_comb begin
    w_req    = mem_read | mem_write;
    // With LATENCY=1 the read happens on the accepting edge, before r_addr is loaded.
    w_rd_idx = (r_state == IDLE) ? mem_addr[DEPTH_LOG2-1:0] : r_addr;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_op_wr <= mem_write;
            r_addr  <= mem_addr[DEPTH_LOG2-1:0];
            r_wdata <= mem_wdata;
            r_cnt   <= LAT_M1;
            if (LATENCY == 1) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              if (!mem_write) r_rdata <= r_mem[w_rd_idx];
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (r_cnt == 8'd1) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_cnt   <= '0;
            if (!r_op_wr) r_rdata <= r_mem[w_rd_idx];
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the line array is deliberately not reset; clearing it would block RAM inference.
  always_ff @(posedge clk) begin
    if (!proc_reset && (r_state == RESP) && r_op_wr)
      r_mem[r_addr] <= r_wdata;
  end

  assign mem_rdata = r_rdata;
  assign mem_ready = r_ready;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a LATENCY=8 instance and a LATENCY=1 instance,
// with a scoreboard queue of expected completions and a line model for expected read data.
module tb_line_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         rd0, wr0, rd1, wr1;
  logic [27:0]  addr0, addr1;
  logic [127:0] wd0, wd1;
  logic [127:0] rdata0, rdata1;
  logic         rdy0, rdy1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic         is_read;
    logic [127:0] data;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] model0[int];
  logic [127:0] model1[int];
  logic [127:0] last_rd0 = '0;
  logic [127:0] last_rd1 = '0;

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
  localparam logic [127:0] D3 = 128'h0F0F0F0F_F0F0F0F0_11112222_33334444;
  localparam logic [127:0] D4 = 128'hFEEDFACE_CAFEBABE_DEADBEEF_12345678;

  line_mem_responder u_dut0 (
    .clk(clk), .proc_reset(rst), .mem_read(rd0), .mem_write(wr0),
    .mem_addr(addr0), .mem_wdata(wd0), .mem_rdata(rdata0), .mem_ready(rdy0)
  );

  line_mem_responder #(.LATENCY(1), .DEPTH_LOG2(4)) u_dut1 (
    .clk(clk), .proc_reset(rst), .mem_read(rd1), .mem_write(wr1),
    .mem_addr(addr1), .mem_wdata(wd1), .mem_rdata(rdata1), .mem_ready(rdy1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [27:0] addr, input logic [127:0] wd);
    if (sel) begin
      rd1 = rd; wr1 = wr; addr1 = addr; wd1 = wd;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = addr; wd0 = wd;
    end
  endtask

  // One transaction from IDLE. Latency is counted in edges from the accepting edge (edge 1)
  // up to the edge after which mem_ready is seen high: LATENCY=1 gives 1, LATENCY=8 gives 8.
  task automatic txn(input bit sel, input logic rd, input logic wr,
                     input logic [27:0] addr, input logic [27:0] busy_addr,
                     input logic [127:0] wd, input int lat, input string tag);
    exp_t e;
    int   idx;
    int   cyc;
    logic got;
    idx = sel ? int'(addr[3:0]) : int'(addr[9:0]);
    e.is_read = !wr;
    if (wr) begin
      e.data = sel ? last_rd1 : last_rd0;
      if (sel) model1[idx] = wd; else model0[idx] = wd;
    end else begin
      e.data = sel ? model1[idx] : model0[idx];
      if (sel) last_rd1 = e.data; else last_rd0 = e.data;
    end
    sb_q.push_back(e);
    drive(sel, rd, wr, addr, wd);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 300) begin
      tick();
      cyc++;
      if (cyc == 1) drive(sel, rd, wr, busy_addr, wd);
      got = sel ? rdy1 : rdy0;
    end
    drive(sel, 1'b0, 1'b0, busy_addr, wd);
    check({tag, " latency"}, 128'(cyc), 128'(lat));
    e = sb_q.pop_front();
    check({tag, " rdata"}, sel ? rdata1 : rdata0, e.data);
    tick();
    check({tag, " ready single"}, 128'(sel ? rdy1 : rdy0), 128'(0));
    check({tag, " rdata hold"}, sel ? rdata1 : rdata0, e.data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int pulses;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick(); tick(); tick();
    check("reset ready0", 128'(rdy0), 128'(0));
    check("reset rdata0", rdata0, '0);
    check("reset ready1", 128'(rdy1), 128'(0));
    check("reset rdata1", rdata1, '0);
    rst = 1'b0;
    tick();

    txn(0, 1'b0, 1'b1, 28'h0000010, 28'h0000010, D1, 8, "wr10");
    txn(0, 1'b1, 1'b0, 28'h0000010, 28'h0000010, '0, 8, "rd10");

    txn(0, 1'b0, 1'b1, 28'h0000405, 28'h0000405, 128'h1, 8, "wr405");
    txn(0, 1'b1, 1'b0, 28'h0000005, 28'h0000005, '0, 8, "rd005 alias");

    // Both requests high: handled as a write, mem_rdata keeps the previous read value.
    txn(0, 1'b1, 1'b1, 28'h0000010, 28'h0000010, D2, 8, "rdwr prio");
    txn(0, 1'b1, 1'b0, 28'h0000010, 28'h0000010, '0, 8, "rd10 after prio");

    txn(0, 1'b0, 1'b1, 28'h0000020, 28'h0000020, D3, 8, "wr20");
    txn(0, 1'b1, 1'b0, 28'h0000010, 28'h0000020, '0, 8, "rd10 addr change");

    // Reset three cycles after accepting a write: the pending write is dropped.
    txn(0, 1'b0, 1'b1, 28'h0000030, 28'h0000030, 128'hCAFE, 8, "wr30");
    drive(0, 1'b0, 1'b1, 28'h0000030, 128'hDEAD);
    tick();
    check("midrst ready e0", 128'(rdy0), 128'(0));
    tick();
    check("midrst ready e1", 128'(rdy0), 128'(0));
    tick();
    check("midrst ready e2", 128'(rdy0), 128'(0));
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 28'h0000030, 128'hDEAD);
    tick();
    rst = 1'b0;
    last_rd0 = '0;
    last_rd1 = '0;
    check("midrst ready", 128'(rdy0), 128'(0));
    check("midrst rdata cleared", rdata0, '0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rdy0) pulses++;
    end
    check("midrst no late ready", 128'(pulses), 128'(0));
    txn(0, 1'b1, 1'b0, 28'h0000030, 28'h0000030, '0, 8, "rd30 after reset");

    // Read held high: pulses every LATENCY+1 cycles, never adjacent.
    drive(0, 1'b1, 1'b0, 28'h0000010, '0);
    prev = 0;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (rdy0) begin
        pulses++;
        check("held rdata", rdata0, D2);
        check("held spacing", 128'(c - prev), 128'((prev == 0) ? 8 : 9));
        prev = c;
      end
    end
    check("held pulse count", 128'(pulses), 128'(4));
    drive(0, 1'b0, 1'b0, 28'h0000010, '0);
    for (int i = 0; i < 12; i++) tick();

    txn(1, 1'b0, 1'b1, 28'h0000003, 28'h0000003, D4, 1, "l1 wr3");
    txn(1, 1'b1, 1'b0, 28'h0000013, 28'h0000013, '0, 1, "l1 rd13 alias");

    drive(1, 1'b1, 1'b0, 28'h0000003, '0);
    prev = 0;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (rdy1) begin
        pulses++;
        check("l1 held rdata", rdata1, D4);
        check("l1 held spacing", 128'(c - prev), 128'((prev == 0) ? 1 : 2));
        prev = c;
      end
    end
    check("l1 held pulse count", 128'(pulses), 128'(5));
    drive(1, 1'b0, 1'b0, 28'h0000003, '0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
